block_sync_rx: RTL

BLOCK_SYNC_RX -- requirements
Module: block_sync_rx

---
 rtl/block_sync_rx_pkg.sv | 23 ++
 rtl/block_sync_rx_if.sv | 26 ++
 rtl/block_sync_rx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/block_sync_rx_pkg.sv
// Shared PCS definitions for the block sync receiver: FSM states,
// lock window constants and the valid sync header encodings.
package block_sync_rx_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_TEST = 2'd1,
    ST_HOLD = 2'd2
  } sync_state_t;

  // Headers per lock test window, and invalid headers per window that drop lock.
  localparam int SH_CNT_MAX = 64;
  localparam int SH_INV_MAX = 16;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

  // A header is valid when its two bits differ (data or control block).
  function automatic logic sh_valid(input logic [1:0] hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_rx_if.sv
// Gearbox-side bus of the block sync receiver. slave = receiver side,
// master = the gearbox/driver side.
interface block_sync_rx_if #(
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64
);
  logic              signal_ok_i;
  logic              valid_i;
  logic [HEAD_W-1:0] head_i;
  logic [DATA_W-1:0] data_i;
  logic              slip_v_o;
  logic              lock_o;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;

  modport slave (
    input  signal_ok_i, valid_i, head_i, data_i,
    output slip_v_o, lock_o, valid_o, head_o, data_o
  );

  modport master (
    output signal_ok_i, valid_i, head_i, data_i,
    input  slip_v_o, lock_o, valid_o, head_o, data_o
  );
endinterface

// File: rtl/block_sync_rx.sv
// Block sync receiver: hunts for 64 consecutive valid sync headers to
// declare lock, drops lock on 16 bad headers within a 64-block window,
// and requests a gearbox slip on every realignment decision.
module block_sync_rx
  import block_sync_rx_pkg::*;
#(
  parameter int HEAD_W    = 2,
  parameter int DATA_W    = 64,
  parameter int SLIP_HOLD = 2
) (
  input  logic           clk,
  input  logic           reset,
  block_sync_rx_if.slave bus
);

  localparam int SH_CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int SH_INV_W = $clog2(SH_INV_MAX + 1);
  localparam int HOLD_W   = (SLIP_HOLD < 1) ? 1 : $clog2(SLIP_HOLD + 1);

  localparam logic [SH_CNT_W-1:0] SH_CNT_TOP    = SH_CNT_W'(SH_CNT_MAX);
  localparam logic [SH_INV_W-1:0] SH_INV_TOP    = SH_INV_W'(SH_INV_MAX);
  localparam logic [HOLD_W-1:0]   SLIP_HOLD_TOP = HOLD_W'(SLIP_HOLD);

  sync_state_t         state_q, state_d;
  logic                lock_q, lock_d;
  logic                slip_q, slip_d;
  logic                valid_q, valid_d;
  logic [SH_CNT_W-1:0] sh_cnt_q, sh_cnt_d, sh_inc;
  logic [SH_INV_W-1:0] sh_inv_q, sh_inv_d, inv_inc;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
  logic                hdr_ok;
  logic [HEAD_W-1:0]   head_q;
  logic [DATA_W-1:0]   data_q;

  // Control state register; reset wins over everything, no slip on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      lock_q   <= 1'b0;
      slip_q   <= 1'b0;
      valid_q  <= 1'b0;
      sh_cnt_q <= '0;
      sh_inv_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      slip_q   <= slip_d;
      valid_q  <= valid_d;
      sh_cnt_q <= sh_cnt_d;
      sh_inv_q <= sh_inv_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state logic: header testing, lock/loss decisions and slip requests.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    slip_d   = 1'b0;
    sh_cnt_d = sh_cnt_q;
    sh_inv_d = sh_inv_q;
    hold_d   = hold_q;
    sh_inc   = sh_cnt_q + SH_CNT_W'(1);
    inv_inc  = sh_inv_q + SH_INV_W'(1);
    hold_inc = hold_q + HOLD_W'(1);
    hdr_ok   = sh_valid(bus.head_i[1:0]);

    if (!bus.signal_ok_i) begin
      // Loss of signal: back to INIT quietly, whatever else happens this cycle.
      state_d  = ST_INIT;
      lock_d   = 1'b0;
      sh_cnt_d = '0;
      sh_inv_d = '0;
      hold_d   = '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          state_d  = ST_TEST;
          lock_d   = 1'b0;
          sh_cnt_d = '0;
          sh_inv_d = '0;
          hold_d   = '0;
        end
        ST_TEST: begin
          if (bus.valid_i) begin
            if (!lock_q) begin
              if (!hdr_ok) begin
                // Hunting: any bad header means the alignment is wrong.
                slip_d   = 1'b1;
                sh_cnt_d = '0;
                sh_inv_d = '0;
                hold_d   = '0;
                state_d  = ST_HOLD;
              end else if (sh_inc == SH_CNT_TOP) begin
                lock_d   = 1'b1;
                sh_cnt_d = '0;
                sh_inv_d = '0;
              end else begin
                sh_cnt_d = sh_inc;
              end
            end else begin
              if (!hdr_ok && (inv_inc == SH_INV_TOP)) begin
                // Too many bad headers in this window: loss of lock.
                lock_d   = 1'b0;
                slip_d   = 1'b1;
                sh_cnt_d = '0;
                sh_inv_d = '0;
                hold_d   = '0;
                state_d  = ST_HOLD;
              end else if (sh_inc == SH_CNT_TOP) begin
                // Window complete with lock intact: start a fresh window.
                sh_cnt_d = '0;
                sh_inv_d = '0;
              end else begin
                sh_cnt_d = sh_inc;
                if (!hdr_ok) sh_inv_d = inv_inc;
              end
            end
          end
        end
        ST_HOLD: begin
          // Let the gearbox settle after a slip before testing again.
          if (bus.valid_i) begin
            if (hold_inc >= SLIP_HOLD_TOP) begin
              hold_d  = '0;
              state_d = ST_TEST;
            end else begin
              hold_d = hold_inc;
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    // The block that completes lock is itself forwarded as valid.
    valid_d = bus.valid_i & lock_d;
  end

  // Payload capture on every valid block; not reset, only meaningful with valid_o.
  always_ff @(posedge clk) begin
    if (bus.valid_i) begin
      head_q <= bus.head_i;
      data_q <= bus.data_i;
    end
  end

  assign bus.slip_v_o = slip_q;
  assign bus.lock_o   = lock_q;
  assign bus.valid_o  = valid_q;
  assign bus.head_o   = head_q;
  assign bus.data_o   = data_q;

  // A slip always leads to HOLD, so two back-to-back slips are impossible.
  a_slip_single: assert property (@(posedge clk) disable iff (reset) slip_q |=> !slip_q);

  // Lock is only ever held while testing headers.
  a_lock_in_test: assert property (@(posedge clk) disable iff (reset) lock_q |-> (state_q == ST_TEST));

endmodule
